// File: rtl/dmem_responder_pkg.sv
// +-----------------------------------------------------------------------+
// | dmem_pkg : shared types and default constants for dmem_responder      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int RD_LAT_DEF = 2;
  localparam int CNT_W_DEF  = 4;
  localparam int DATA_W     = 32;
  localparam int IDX_MAX_W  = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } state_t;

  typedef struct packed {
    logic                 rnw;
    logic [IDX_MAX_W-1:0] index;
    logic [DATA_W-1:0]    data;
  } req_t;

  // Full word index of a byte address; callers keep only the bits they need.
  function automatic logic [IDX_MAX_W-1:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// +-----------------------------------------------------------------------+
// | dmem_responder_if : data-memory request/response bus                  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface dmem_responder_if;
  logic        m_sel;
  logic        m_rnw;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [31:0] s_data;
  logic        s_ack;
  logic        s_busy;
  logic        s_err;

  modport master (
    output m_sel, m_rnw, m_addr, m_data,
    input  s_data, s_ack, s_busy, s_err
  );

  modport slave (
    input  m_sel, m_rnw, m_addr, m_data,
    output s_data, s_ack, s_busy, s_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder_ram_sp.sv
// +-----------------------------------------------------------------------+
// | dmem_ram_sp : single-port word RAM, synchronous write, async read     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module dmem_ram_sp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] addr,
  input  wire logic [DATA_W-1:0] wdata,
  output logic      [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +-----------------------------------------------------------------------+
// | dmem_responder : data-memory responder with programmable read latency |
// | Optional address checking: DMEM_RESPONDER_ADDR_CHECK_EN               |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input wire logic         clk,
  input wire logic         rst,
  dmem_responder_if.slave  bus
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  req_t                req_q, req_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   s_data_q, s_data_d;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [ADDR_W-1:0]   acc_idx;
  logic [DATA_W-1:0]   ram_rdata;
  logic                addr_err;
  logic                unused_req;

  assign acc_idx    = bus.m_addr[ADDR_W+1:2];
  assign unused_req = ^req_q;

`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
  assign addr_err = (bus.m_addr[1:0] != 2'b00) ||
                    ((bus.m_addr >> (ADDR_W + 2)) != 32'd0);
`else
  logic unused_addr_bits;
  assign addr_err         = 1'b0;
  assign unused_addr_bits = ^{bus.m_addr[1:0], bus.m_addr[31:ADDR_W+2]};
`endif

  // The RAM address follows the live request while idle so a write can
  // commit and an RD_LAT=1 read can load s_data on the accept edge itself.
  assign ram_addr = (state_q == IDLE) ? acc_idx : req_q.index[ADDR_W-1:0];

  dmem_ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.m_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    err_d    = err_q;
    s_data_d = s_data_q;
    ram_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.m_sel) begin
          req_d.rnw   = bus.m_rnw;
          req_d.index = word_index(bus.m_addr);
          req_d.data  = bus.m_data;
          err_d       = addr_err;
          if (!bus.m_rnw) begin
            ram_we  = !addr_err;
            state_d = ACK;
          end else begin
            cnt_d = CNT_W'(RD_LAT - 1);
            if (RD_LAT == 1) begin
              state_d = ACK;
              if (!addr_err) begin
                s_data_d = ram_rdata;
              end
            end else begin
              state_d = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ACK;
          if (!err_q) begin
            s_data_d = ram_rdata;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      err_q    <= 1'b0;
      s_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      err_q    <= err_d;
      s_data_q <= s_data_d;
    end
  end

  assign bus.s_data = s_data_q;
  assign bus.s_ack  = (state_q == ACK);
  assign bus.s_busy = (state_q != IDLE);
  assign bus.s_err  = (state_q == ACK) && err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: RD_LAT=2 instance (a) and RD_LAT=1 instance (b),
// checked against an associative-array memory model.
`default_nettype none

module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.ADDR_W(10), .RD_LAT(2), .CNT_W(4)) u_dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  dmem_responder #(.ADDR_W(10), .RD_LAT(1), .CNT_W(4)) u_dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  always #5 clk = ~clk;

  logic use_b = 1'b0;
  wire        obs_ack  = use_b ? bus_b.s_ack  : bus_a.s_ack;
  wire        obs_busy = use_b ? bus_b.s_busy : bus_a.s_busy;
  wire        obs_err  = use_b ? bus_b.s_err  : bus_a.s_err;
  wire [31:0] obs_data = use_b ? bus_b.s_data : bus_a.s_data;

  // Reference model: word memories and last completed read per instance.
  logic [31:0] mem_a [int];
  logic [31:0] mem_b [int];
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_b = 32'd0;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
    return ((a % 32'd4) != 32'd0) || (a >= 32'h1000);
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_bus(input logic b, input logic sel, input logic rnw,
                         input logic [31:0] addr, input logic [31:0] wd);
    if (b) begin
      bus_b.m_sel = sel; bus_b.m_rnw = rnw; bus_b.m_addr = addr; bus_b.m_data = wd;
    end else begin
      bus_a.m_sel = sel; bus_a.m_rnw = rnw; bus_a.m_addr = addr; bus_a.m_data = wd;
    end
  endtask

  // One request on an idle DUT; call 1 time unit after a rising edge.
  task automatic do_req(input logic b, input logic rnw, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic er, output int busy_n);
    use_b  = b;
    lat    = 0;
    busy_n = 0;
    rd     = 32'hx;
    er     = 1'bx;
    set_bus(b, 1'b1, rnw, addr, wd);
    @(posedge clk); #1;
    set_bus(b, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 1; i <= 20; i++) begin
      if (obs_busy) busy_n++;
      if (obs_ack) begin
        lat = i; rd = obs_data; er = obs_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // Model update for a completed request on instance a.
  task automatic model_a(input logic rnw, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] exp_rd);
    if (!exp_err(addr)) begin
      if (rnw) last_a = mem_a[widx(addr)];
      else     mem_a[widx(addr)] = wd;
    end
    exp_rd = last_a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_bus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      use_b = (k == 1);
      #0;
      tests++;
      if ({obs_data, obs_ack, obs_busy, obs_err} !== 35'd0) begin
        fails++;
        $display("FAIL reset_outputs dut%0d: got data=%h ack=%b busy=%b err=%b, want all 0",
                 k, obs_data, obs_ack, obs_busy, obs_err);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat, bn; logic [31:0] rd, ex; logic er;
    do_req(1'b0, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, bn);
    model_a(1'b0, 32'h10, 32'hDEADBEEF, ex);
    tests++;
    if (lat !== 1 || bn !== 1) begin
      fails++; $display("FAIL wr_latency: got lat=%0d busy=%0d, want 1/1", lat, bn);
    end
    tests++;
    if (rd !== ex) begin
      fails++; $display("FAIL wr_keeps_sdata: got %h, want %h", rd, ex);
    end
    tests++;
    if (obs_busy !== 1'b0 || obs_ack !== 1'b0) begin
      fails++; $display("FAIL wr_idle_after: got busy=%b ack=%b, want 0/0", obs_busy, obs_ack);
    end
    do_req(1'b0, 1'b1, 32'h10, 32'd0, lat, rd, er, bn);
    model_a(1'b1, 32'h10, 32'd0, ex);
    tests++;
    if (lat !== 2 || bn !== 2) begin
      fails++; $display("FAIL rd_latency: got lat=%0d busy=%0d, want 2/2", lat, bn);
    end
    tests++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      fails++; $display("FAIL rd_data: got %h err=%b, want deadbeef err=0", rd, er);
    end
    tests++;
    if (obs_busy !== 1'b0 || obs_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rd_hold: got busy=%b data=%h, want 0/deadbeef", obs_busy, obs_data);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bn; logic [31:0] rd, ex; logic er;
    logic [31:0] d [4];
    logic exp_ack [4];
    do_req(1'b1, 1'b0, 32'h4, 32'h11111111, lat, rd, er, bn);
    do_req(1'b1, 1'b0, 32'h8, 32'h22222222, lat, rd, er, bn);
    use_b = 1'b1;
    set_bus(1'b1, 1'b1, 1'b1, 32'h4, 32'd0);
    @(posedge clk); #1;
    tests++;
    if (obs_ack !== 1'b1 || obs_data !== 32'h11111111) begin
      fails++; $display("FAIL b2b_rd0: got ack=%b data=%h, want 1/11111111", obs_ack, obs_data);
    end
    set_bus(1'b1, 1'b1, 1'b1, 32'h8, 32'd0);
    @(posedge clk); #1;
    tests++;
    if (obs_ack !== 1'b0 || obs_busy !== 1'b0 || obs_data !== 32'h11111111) begin
      fails++; $display("FAIL b2b_gap: got ack=%b busy=%b data=%h, want 0/0/11111111",
                        obs_ack, obs_busy, obs_data);
    end
    @(posedge clk); #1;
    tests++;
    if (obs_ack !== 1'b1 || obs_data !== 32'h22222222) begin
      fails++; $display("FAIL b2b_rd1: got ack=%b data=%h, want 1/22222222", obs_ack, obs_data);
    end
    set_bus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;

    // Held write strobe on instance a: only every second cycle is accepted.
    use_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d[k] = $urandom;
      exp_ack[k] = ((k % 2) == 0);
    end
    for (int k = 0; k < 4; k++) begin
      set_bus(1'b0, 1'b1, 1'b0, 32'h40, d[k]);
      @(posedge clk); #1;
      tests++;
      if (obs_ack !== exp_ack[k]) begin
        fails++; $display("FAIL b2b_wr_ack%0d: got %b, want %b", k, obs_ack, exp_ack[k]);
      end
    end
    set_bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    mem_a[widx(32'h40)] = d[2];
    do_req(1'b0, 1'b1, 32'h40, 32'd0, lat, rd, er, bn);
    model_a(1'b1, 32'h40, 32'd0, ex);
    tests++;
    if (rd !== ex) begin
      fails++; $display("FAIL b2b_wr_result: got %h, want %h", rd, ex);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, bn; logic [31:0] rd, ex; logic er;
    do_req(1'b0, 1'b0, 32'h20, 32'h12345678, lat, rd, er, bn);
    model_a(1'b0, 32'h20, 32'h12345678, ex);
    use_b = 1'b0;
    set_bus(1'b0, 1'b1, 1'b1, 32'h20, 32'd0);
    @(posedge clk); #1;
    set_bus(1'b0, 1'b1, 1'b0, 32'h20, 32'hAAAA5555);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (obs_ack) begin
        lat = i; rd = obs_data;
        break;
      end
      @(posedge clk); #1;
    end
    set_bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    model_a(1'b1, 32'h20, 32'd0, ex);
    tests++;
    if (lat !== 2 || rd !== 32'h12345678) begin
      fails++; $display("FAIL busy_rd: got lat=%0d data=%h, want 2/12345678", lat, rd);
    end
    @(posedge clk); #1;
    do_req(1'b0, 1'b1, 32'h20, 32'd0, lat, rd, er, bn);
    tests++;
    if (rd !== 32'h12345678) begin
      fails++; $display("FAIL busy_wr_ignored: got %h, want 12345678", rd);
    end
  endtask

  task automatic test_random();
    int lat, bn; logic [31:0] rd, ex, addr, wd; logic er, rnw;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      do_req(1'b0, 1'b0, i * 4, wd, lat, rd, er, bn);
      model_a(1'b0, i * 4, wd, ex);
    end
    for (int n = 0; n < 40; n++) begin
      rnw  = $urandom_range(0, 1);
      addr = $urandom_range(0, 15) * 4;
      if ($urandom_range(0, 3) == 0) addr += $urandom_range(1, 7) << 12;
      if ($urandom_range(0, 7) == 0) addr += $urandom_range(1, 3);
      wd = $urandom;
      do_req(1'b0, rnw, addr, wd, lat, rd, er, bn);
      model_a(rnw, addr, wd, ex);
      tests++;
      if (lat !== (rnw ? 2 : 1) || bn !== lat || rd !== ex || er !== exp_err(addr)) begin
        fails++;
        $display("FAIL random%0d rnw=%b addr=%h: got lat=%0d busy=%0d data=%h err=%b, want lat=%0d data=%h err=%b",
                 n, rnw, addr, lat, bn, rd, er, rnw ? 2 : 1, ex, exp_err(addr));
      end
    end
  endtask

  task automatic test_addr_map();
    int lat, bn; logic [31:0] rd, ex, ram0; logic er;
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
    ram0 = mem_a[0];
    do_req(1'b0, 1'b1, 32'h6, 32'd0, lat, rd, er, bn);
    model_a(1'b1, 32'h6, 32'd0, ex);
    tests++;
    if (lat !== 2 || er !== 1'b1 || rd !== ex) begin
      fails++; $display("FAIL err_rd: got lat=%0d err=%b data=%h, want 2/1/%h", lat, er, rd, ex);
    end
    do_req(1'b0, 1'b0, 32'h1000, 32'h0BADF00D, lat, rd, er, bn);
    model_a(1'b0, 32'h1000, 32'h0BADF00D, ex);
    tests++;
    if (lat !== 1 || er !== 1'b1) begin
      fails++; $display("FAIL err_wr: got lat=%0d err=%b, want 1/1", lat, er);
    end
    do_req(1'b0, 1'b1, 32'h0, 32'd0, lat, rd, er, bn);
    model_a(1'b1, 32'h0, 32'd0, ex);
    tests++;
    if (rd !== ram0 || er !== 1'b0) begin
      fails++; $display("FAIL err_wr_ram0: got %h err=%b, want %h err=0", rd, er, ram0);
    end
`else
    ram0 = 32'hCAFEF00D;
    do_req(1'b0, 1'b0, 32'h1004, ram0, lat, rd, er, bn);
    model_a(1'b0, 32'h1004, ram0, ex);
    do_req(1'b0, 1'b1, 32'h4, 32'd0, lat, rd, er, bn);
    model_a(1'b1, 32'h4, 32'd0, ex);
    tests++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      fails++; $display("FAIL wrap_rd: got %h err=%b, want cafef00d err=0", rd, er);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int lat, bn, acks; logic [31:0] rd, ex, v; logic er;
    v = $urandom | 32'h1;
    do_req(1'b0, 1'b0, 32'h30, v, lat, rd, er, bn);
    model_a(1'b0, 32'h30, v, ex);
    do_req(1'b0, 1'b1, 32'h30, 32'd0, lat, rd, er, bn);
    model_a(1'b1, 32'h30, 32'd0, ex);
    use_b = 1'b0;
    set_bus(1'b0, 1'b1, 1'b1, 32'h30, 32'd0);
    @(posedge clk); #1;
    set_bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tests++;
    if (obs_busy !== 1'b1 || obs_ack !== 1'b0 || obs_data !== v) begin
      fails++; $display("FAIL rst_pre: got busy=%b ack=%b data=%h, want 1/0/%h",
                        obs_busy, obs_ack, obs_data, v);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({obs_data, obs_ack, obs_busy, obs_err} !== 35'd0) begin
      fails++; $display("FAIL rst_async: got data=%h ack=%b busy=%b err=%b, want all 0",
                        obs_data, obs_ack, obs_busy, obs_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_a = 32'd0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      if (obs_ack) acks++;
      @(posedge clk); #1;
    end
    tests++;
    if (acks !== 0) begin
      fails++; $display("FAIL rst_no_ack: got %0d acks, want 0", acks);
    end
    do_req(1'b0, 1'b1, 32'h30, 32'd0, lat, rd, er, bn);
    model_a(1'b1, 32'h30, 32'd0, ex);
    tests++;
    if (lat !== 2 || rd !== v) begin
      fails++; $display("FAIL rst_ram_kept: got lat=%0d data=%h, want 2/%h", lat, rd, v);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_busy_ignore();
    test_random();
    test_addr_map();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory master port (m_sel / m_rnw / m_addr / m_data out, s_data in).
- Accepts one word request at a time and holds it in a word-addressed RAM.
- Reads complete after a programmable wait-state count; writes are acknowledged one cycle after acceptance.
- Sits between the pipeline's memory stage and the data RAM. It is the bench/SoC-side model and the synthesizable data memory.

Parameters:
- ADDR_W, 10: word-index width; the RAM depth is 2**ADDR_W words.
- RD_LAT, 2: read wait cycles from acceptance to s_ack. Legal range 1..15.
- CNT_W, 4: width of the latency counter.

Ports:
- clk  in  1  : the single clock.
- rst  in  1  : reset, asynchronous and active-high.
- m_sel  in  1  : request strobe from the master.
- m_rnw  in  1  : 1 = read, 0 = write.
- m_addr  in  32  : byte address.
- m_data  in  32  : write data.
- s_data  out  32  : read data returned to the master.
- s_ack  out  1  : one-cycle completion pulse.
- s_busy  out  1  : request in flight; new requests are ignored while high.
- s_err  out  1  : address error, qualified by s_ack.

Behaviour:
- Reset values: s_data=0, s_ack=0, s_busy=0, s_err=0, state=IDLE, counter=0. RAM contents are NOT reset.
- Word index is m_addr[ADDR_W+1:2]. Bits [1:0] and bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM size.
- FSM states: IDLE, RD_WAIT, ACK.
- IDLE with m_sel=1 accepts the request on that edge and latches rnw, index and data.
- Accepted write (m_rnw=0):
  - RAM[index] <= m_data on the accept edge.
  - Next state is ACK.
  - Write latency is 1: s_ack is high the cycle after acceptance.
- Accepted read (m_rnw=1):
  - counter <= RD_LAT-1.
  - If RD_LAT=1, go to ACK directly; otherwise go to RD_WAIT.
- RD_WAIT decrements the counter each cycle and moves to ACK when the counter reaches 1.
- On entry to ACK for a read, s_data is loaded with RAM[index]. Total read latency is RD_LAT cycles from the accept edge to s_ack high.
- ACK state:
  - s_ack=1 for exactly one cycle, then return to IDLE.
  - A request with m_sel high during ACK is NOT accepted. The earliest next accept is the cycle after ACK.
- s_busy=1 in RD_WAIT and ACK, and also the cycle after a write accept; 0 in IDLE.
- Any m_sel activity while s_busy=1 is ignored: no latch and no RAM write.
- s_data holds the last completed read value through writes and idle cycles. Writes never change s_data.
- Back-to-back requests: with m_sel held high, requests are accepted every RD_LAT+1 cycles for reads and every 2 cycles for writes.
- Reset mid-operation:
  - All FSM state is aborted immediately and no s_ack is issued for the in-flight request.
  - A write already committed on its accept edge stays in RAM.
- s_err is 0 whenever s_ack is 0.

Optional Feature:
- Macro: DMEM_RESPONDER_ADDR_CHECK_EN.
- When defined, the accept edge latches an error flag if m_addr[1:0]!=0 (misaligned) or any bit above ADDR_W+1 is set (out of range).
  - An errored write does not modify RAM.
  - An errored read leaves s_data unchanged.
  - The latency is unchanged and s_err=1 together with s_ack.
- When not defined, s_err is tied to 0, the address wraps as described above, and the low bits are ignored.

Decomposition:
- Shared package dmem_pkg holds:
  - the state encoding enum (IDLE=2'd0, RD_WAIT=2'd1, ACK=2'd2);
  - the request struct {rnw, index, data};
  - the default constants for ADDR_W and RD_LAT.
- Natural sub-module: dmem_ram_sp, a single-port synchronous-write, combinational-read word array with write enable. The FSM and counter stay in dmem_responder.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 with RD_LAT=2:
  - s_ack is high 1 cycle after the write accept;
  - the read gives s_ack 2 cycles after accept with s_data=0xDEADBEEF;
  - s_busy is high exactly over those intervals.
- RD_LAT=1, two back-to-back reads of 0x4 (holding 0x11111111) and 0x8 (holding 0x22222222) with m_sel held high:
  - accepts occur every 2 cycles;
  - s_data sequence is 0x11111111 then 0x22222222.
- Issue a write of 0xAAAA5555 to 0x20 while s_busy=1 from a pending read of 0x20 (holding 0x12345678):
  - the write is ignored;
  - the read returns 0x12345678;
  - a subsequent read of 0x20 still returns 0x12345678.
- Wrap, macro off, ADDR_W=10: write 0xCAFEF00D to 0x0000_1004, then read 0x0000_0004 -> 0xCAFEF00D with s_err=0.
- Macro on:
  - reading 0x0000_0006 -> s_ack with s_err=1 and s_data unchanged;
  - writing 0x0000_1000 -> s_err=1 and RAM[0] unchanged.
- Assert rst during RD_WAIT of a read:
  - outputs drop to 0 asynchronously and no s_ack follows;
  - data written to 0x30 before the reset reads back correctly afterwards.
